// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div ops over a fixed
// latency and serves mfhi/mflo/mthi/mtlo.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] R1,
   input  logic [31:0] R2,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_MFHI  = 4'b0101;
   localparam logic [3:0] OP_MFLO  = 4'b0110;
   localparam logic [3:0] OP_MTHI  = 4'b0111;
   localparam logic [3:0] OP_MTLO  = 4'b1000;

   typedef enum logic {IDLE, RUN} state_t;

   // Start/Busy handshake: Start acts as valid and !Busy as ready. An op is accepted
   // on a rising edge where Start=1, MDUOp is mult/multu/div/divu and Busy=0; Busy is
   // registered, so the requester must OR in its own Start to cover the issue cycle.
   state_t          state, state_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic [31:0]     hi_n, lo_n, hi_n_d, lo_n_d;
   logic            skip_q, skip_d;
   logic [31:0]     hi_q, lo_q, hi_d, lo_d;

   logic            is_arith, is_mult, is_div;
   logic            div_zero, div_ovf;
   logic [31:0]     dvs;
   logic [63:0]     prod_s, prod_u;
   logic [31:0]     quo_s, rem_s, quo_u, rem_u;
   logic [31:0]     res_hi, res_lo;

   assign is_mult  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
   assign is_div   = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
   assign is_arith = is_mult || is_div;

   assign prod_s = $signed({{32{R1[31]}}, R1}) * $signed({{32{R2[31]}}, R2});
   assign prod_u = {32'b0, R1} * {32'b0, R2};

   // Zero and INT_MIN/-1 divisors are replaced by 1: the zero case is discarded at
   // commit, and INT_MIN/1 already yields the required quotient 0x80000000, rem 0.
   assign div_zero = (R2 == 32'd0);
   assign div_ovf  = (MDUOp == OP_DIV) && (R1 == 32'h8000_0000) && (R2 == 32'hFFFF_FFFF);
   assign dvs      = (div_zero || div_ovf) ? 32'd1 : R2;

   assign quo_s = $unsigned($signed(R1) / $signed(dvs));
   assign rem_s = $unsigned($signed(R1) % $signed(dvs));
   assign quo_u = R1 / dvs;
   assign rem_u = R1 % dvs;

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (MDUOp)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV:   begin res_hi = rem_s; res_lo = quo_s; end
         OP_DIVU:  begin res_hi = rem_u; res_lo = quo_u; end
         default:  begin res_hi = 32'd0; res_lo = 32'd0; end
      endcase
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      hi_n_d  = hi_n;
      lo_n_d  = lo_n;
      skip_d  = skip_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state)
         IDLE: begin
            if (Start && is_arith) begin
               state_d = RUN;
               cnt_d   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
               hi_n_d  = res_hi;
               lo_n_d  = res_lo;
               skip_d  = is_div && div_zero;
            end else if (MDUOp == OP_MTHI) begin
               hi_d = R1;
            end else if (MDUOp == OP_MTLO) begin
               lo_d = R1;
            end
         end
         RUN: begin
            cnt_d = cnt - CW'(1);
            if (cnt <= CW'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (!skip_q) begin
                  hi_d = hi_n;
                  lo_d = lo_n;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_n   <= 32'd0;
         lo_n   <= 32'd0;
         skip_q <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         hi_n   <= hi_n_d;
         lo_n   <= lo_n_d;
         skip_q <= skip_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   assign Busy = (state == RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

   always_comb begin
      MDUOut = 32'd0;
      if (MDUOp == OP_MFHI)      MDUOut = hi_q;
      else if (MDUOp == OP_MFLO) MDUOut = lo_q;
   end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the five-stage pipelined CPU. It sits beside the ALU and takes the same forwarded operand pair. It runs `mult`/`multu`/`div`/`divu` over a fixed multi-cycle latency and owns the HI/LO registers. It also serves `mfhi`/`mflo`/`mthi`/`mtlo`, drives `Busy` to the hazard unit, and returns `MDUOut` to the E-stage result mux alongside the ALU's `Rout`.

## Interface
- `MULT_CYCLES`, default 5: Busy cycles for `mult`/`multu` (must be ≥1).
- `DIV_CYCLES`, default 10: Busy cycles for `div`/`divu` (must be ≥1).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `R1`  in  32  operand rs (forwarded).
- `R2`  in  32  operand rt (forwarded).
- `MDUOp`  in  4  operation code:
  - 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu,
  - 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo, others = none.
- `Start`  in  1  one-cycle pulse; qualifies a mult/multu/div/divu in E.
- `Busy`  out  1  registered; high while an operation is in flight.
- `HI`  out  32  current HI register.
- `LO`  out  32  current LO register.
- `MDUOut`  out  32  combinational: HI if mfhi, LO if mflo, else 0.

## Operation
- State: `HI`, `LO`, `Busy`, a countdown counter (4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES)), and pending result regs `hi_n`/`lo_n`.
- States:
  - IDLE (`Busy`=0).
  - RUN (`Busy`=1, counter>0).
  - Return to IDLE commits `hi_n`/`lo_n` to HI/LO.
- IDLE, `Start`=1, MDUOp ∈ {mult, multu, div, divu}:
  - Compute the result from the R1/R2 sampled at that edge into `hi_n`/`lo_n`.
  - Load counter with the op's latency; go to RUN.
- RUN: counter decrements each edge. On the edge where the counter goes 1→0: HI←`hi_n`, LO←`lo_n`, `Busy`←0.
- Arithmetic:
  - `mult`: {HI,LO} = $signed(R1)*$signed(R2), 64-bit.
  - `multu`: the same product, unsigned.
  - `div`: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - `divu`: unsigned quotient to LO, unsigned remainder to HI.
  - `div` 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div/divu): the op still runs its full latency; HI and LO are left unchanged at commit.
- `mthi`/`mtlo`: in IDLE, HI←R1 / LO←R1 at the edge. They need no `Start`.
- Hazard contract: the hazard unit stalls any MDU-class instruction in D while `Start|Busy`. The following are therefore illegal, and for them the block's behaviour is defined as follows:
  - `Start` while `Busy`=1: ignored; the in-flight op is unaffected.
  - mthi/mtlo while `Busy`=1: ignored.
  - mfhi/mflo while `Busy`=1: `MDUOut` returns the committed (old) HI/LO.
- `Start` with MDUOp outside the four arithmetic ops: ignored.
- Reset (any state, including mid-RUN): HI=0, LO=0, `Busy`=0, counter=0. The pending result is discarded.

## Timing
- Reset values: `Busy`=0, `HI`=0, `LO`=0, `MDUOut`=0.
- For `Start` sampled at edge t, with latency N:
  - `Busy`=1 during cycles t+1 … t+N.
  - HI/LO hold their new values from edge t+N onward (readable in cycle t+N+1).
  - `Busy`=0 in cycle t+N+1.
  - A new `Start` is accepted at edge t+N+1 at the earliest.
- `Busy` is purely registered; `Start` does not reach it combinationally. The hazard unit ORs `Start` in itself.
- mthi/mtlo: one-edge latency. `MDUOut` for mfhi/mflo is zero-latency from the current HI/LO.
- Back-to-back mthi then mfhi: the mfhi in the next cycle sees the new value.

## Test plan
- Reset, then mult R1=0xFFFFFFFE (-2), R2=3:
  - `Busy` high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - mflo returns 0xFFFFFFFA.
- multu R1=0xFFFFFFFF, R2=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div R1=-7 (0xFFFFFFF9), R2=2:
  - `Busy` high 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu R1=7, R2=0 → `Busy` high 10 cycles, then HI and LO unchanged. Follow with div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi R1=0x12345678, then mfhi next cycle → MDUOut=0x12345678. Then:
  - Start mult 2×3 and pulse mtlo at cycle 2 of Busy → mtlo ignored.
  - Mid-Busy mflo returns the old LO.
  - After commit LO=6.
- Start divu 100/7. At cycle 4 of Busy assert `reset` for one cycle → `Busy`=0 and HI=LO=0 next cycle, with no later commit. A Start the cycle after reset deasserts is accepted normally.
